hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
Pipeline sequencing controller for the 16-bit five-stage core. It detects load-use hazards between the decode and execute stages and inserts bubbles through the decode/execute NOP mux. It also flushes fetch/decode on taken branches and freezes the whole pipeline while data memory is busy. Sits beside the decode/execute pipeline register and drives the stall/flush/nop controls of the fetch, decode and execute stage registers.

Parameters:
REG_ADDR_W, 4, register index width (16 registers; R0 is hardwired zero)
LOAD_USE_STALL, 1, bubbles inserted per load-use hazard (legal 1..4)
BRANCH_FLUSH_CYCLES, 2, cycles flush/nop held after a taken branch (legal 1..4)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
valid_decode  in  1  decode stage holds a real instruction
rs1_decode  in  REG_ADDR_W  source register 1 of the decode instruction
rs2_decode  in  REG_ADDR_W  source register 2 of the decode instruction
uses_rs2_decode  in  1  decode instruction reads rs2
rd_execute  in  REG_ADDR_W  destination register in execute
wre_execute  in  1  execute instruction writes the register file
load_execute  in  1  execute instruction is a load
branch_taken_execute  in  1  branch resolved taken in execute
mem_busy  in  1  data memory not ready
stall_fetch  out  1  hold PC and the fetch/decode register
stall_decode  out  1  hold decode-stage state
nop_select  out  1  NOP mux selects the zero control word into decode/execute
flush_fetch_decode  out  1  clear the fetch/decode register
freeze_all  out  1  hold the execute, memory and writeback registers
state_out  out  2  current FSM state
stall_count  out  CNT_W  cycles with stall_decode=1
flush_count  out  CNT_W  cycles with flush_fetch_decode=1

Behaviour:
- Single clock domain. Control outputs are combinational from the state register, the remaining-cycle counter rem and the inputs.
- While reset=1, all control outputs are forced to 0.
- Next clock with reset=1: state=RUN, rem=0, stall_count=0, flush_count=0.
- Reset mid-stall or mid-flush aborts the sequence immediately.
- States: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3.
- load_use = valid_decode & load_execute & wre_execute & (rd_execute!=0) & ((rd_execute==rs1_decode) | (uses_rs2_decode & rd_execute==rs2_decode)).
- A destination of R0 never causes a hazard.
- RUN evaluation, in priority order mem_busy > branch_taken_execute > load_use:
  - mem_busy: stall_fetch=stall_decode=freeze_all=1; next MEM_WAIT.
  - branch_taken_execute: flush_fetch_decode=nop_select=1; rem<=BRANCH_FLUSH_CYCLES-1; next FLUSH if BRANCH_FLUSH_CYCLES>1, else RUN.
  - load_use: stall_fetch=stall_decode=nop_select=1; rem<=LOAD_USE_STALL-1; next LOAD_STALL if LOAD_USE_STALL>1, else RUN.
  - none of the above: all control outputs 0.
- LOAD_STALL:
  - stall_fetch=stall_decode=nop_select=1; rem<=rem-1; next RUN when rem==1.
  - Total bubbles per hazard = LOAD_USE_STALL.
  - branch_taken_execute is ignored, since execute holds a bubble.
- FLUSH:
  - flush_fetch_decode=nop_select=1, stalls 0; rem<=rem-1; next RUN when rem==1.
  - Total flush cycles = BRANCH_FLUSH_CYCLES.
  - branch_taken_execute and load_use are ignored.
- mem_busy=1 in LOAD_STALL or FLUSH:
  - Overrides that state's outputs: stall_fetch=stall_decode=freeze_all=1, nop_select=0, flush_fetch_decode=0.
  - State and rem are held, and the sequence resumes when mem_busy drops.
- MEM_WAIT:
  - While mem_busy=1: stall_fetch=stall_decode=freeze_all=1, other outputs 0.
  - The cycle mem_busy=0: outputs and next state follow the RUN equations exactly, so a hazard present on release is not missed.
- Counters: stall_count increments on every cycle with stall_decode=1; flush_count on every cycle with flush_fetch_decode=1. Both saturate at all-ones and never wrap.
- state_out mirrors the state register.

Test Plan:
- Load-use via rs1: LOAD with rd_execute=3 and wre_execute=1, decode rs1=3, valid_decode=1 -> exactly 1 cycle of stall_fetch=stall_decode=nop_select=1, then outputs 0; stall_count=1.
- R0 exclusion: load_execute=1, rd_execute=0, rs1_decode=0 -> no stall; also uses_rs2_decode=0 with rs2 matching -> no stall.
- Branch: branch_taken_execute=1 for one cycle in RUN -> flush_fetch_decode=nop_select=1 for 2 cycles, state 0->2->0; flush_count=2.
- Priority: mem_busy=1 coincident with branch_taken and load_use -> only freeze_all and stalls assert, state=MEM_WAIT. On release with branch_taken still 1 -> flush starts in the release cycle.
- mem_busy mid-FLUSH: assert mem_busy in the first FLUSH cycle for 3 cycles -> freeze for 3 cycles with rem held, then 1 remaining flush cycle.
- Reset mid-LOAD_STALL (LOAD_USE_STALL=3) -> outputs 0 during reset, state_out=0 and both counters 0 on the next cycle.
- Saturation: preload stall_count to 16'hFFFF via a long stall -> value remains 16'hFFFF.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// Pipeline hazard control bus: decode/execute hazard inputs and stage control outputs.
// Pure wiring bundle; adds no latency.
// No handshake; the controls are level signals sampled by the stage registers each cycle.
//
// Ports (slave = hazard unit view):
//   in : valid_decode, rs1_decode, rs2_decode, uses_rs2_decode, rd_execute,
//        wre_execute, load_execute, branch_taken_execute, mem_busy
//   out: stall_fetch, stall_decode, nop_select, flush_fetch_decode, freeze_all,
//        state_out, stall_count, flush_count
interface hazard_control_unit_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  valid_decode;
    logic [REG_ADDR_W-1:0] rs1_decode;
    logic [REG_ADDR_W-1:0] rs2_decode;
    logic                  uses_rs2_decode;
    logic [REG_ADDR_W-1:0] rd_execute;
    logic                  wre_execute;
    logic                  load_execute;
    logic                  branch_taken_execute;
    logic                  mem_busy;

    logic                  stall_fetch;
    logic                  stall_decode;
    logic                  nop_select;
    logic                  flush_fetch_decode;
    logic                  freeze_all;
    logic [1:0]            state_out;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    // Pipeline side: drives hazard inputs, consumes the stage controls.
    modport master (
        output valid_decode, rs1_decode, rs2_decode, uses_rs2_decode, rd_execute,
               wre_execute, load_execute, branch_taken_execute, mem_busy,
        input  stall_fetch, stall_decode, nop_select, flush_fetch_decode, freeze_all,
               state_out, stall_count, flush_count
    );

    // Hazard unit side.
    modport slave (
        input  valid_decode, rs1_decode, rs2_decode, uses_rs2_decode, rd_execute,
               wre_execute, load_execute, branch_taken_execute, mem_busy,
        output stall_fetch, stall_decode, nop_select, flush_fetch_decode, freeze_all,
               state_out, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flush, memory-busy freeze.
// Controls are combinational from state/rem/inputs (zero latency); counters update one cycle later.
// mem_busy has top priority and freezes the pipe; a running stall/flush sequence is held, not lost.
//
// Ports: clk, reset (synchronous, active-high), hcu (hazard_control_unit_if.slave)
//   hcu inputs : decode operands, execute destination/load/branch info, mem_busy
//   hcu outputs: stall_fetch, stall_decode, nop_select, flush_fetch_decode, freeze_all,
//                state_out, stall_count, flush_count (saturating)
module hazard_control_unit #(
    parameter int REG_ADDR_W          = 4,
    parameter int LOAD_USE_STALL      = 1,
    parameter int BRANCH_FLUSH_CYCLES = 2,
    parameter int CNT_W               = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_control_unit_if.slave  hcu
);

    localparam int REM_W = 3;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic load_use;
    logic stall_fetch_c, stall_decode_c, nop_select_c, flush_fd_c, freeze_all_c;

    // A destination of R0 is never written, so it can never create a hazard.
    always_comb begin
        load_use = hcu.valid_decode & hcu.load_execute & hcu.wre_execute &
                   (hcu.rd_execute != '0) &
                   ((hcu.rd_execute == hcu.rs1_decode) |
                    (hcu.uses_rs2_decode & (hcu.rd_execute == hcu.rs2_decode)));
    end

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        stall_fetch_c  = 1'b0;
        stall_decode_c = 1'b0;
        nop_select_c   = 1'b0;
        flush_fd_c     = 1'b0;
        freeze_all_c   = 1'b0;

        case (state_q)
            // MEM_WAIT shares the RUN equations: while busy it re-enters MEM_WAIT,
            // and on release a pending branch or load-use is acted on immediately.
            ST_RUN, ST_MEM_WAIT: begin
                if (hcu.mem_busy) begin
                    stall_fetch_c  = 1'b1;
                    stall_decode_c = 1'b1;
                    freeze_all_c   = 1'b1;
                    state_d        = ST_MEM_WAIT;
                end else if (hcu.branch_taken_execute) begin
                    flush_fd_c   = 1'b1;
                    nop_select_c = 1'b1;
                    rem_d        = REM_W'(BRANCH_FLUSH_CYCLES - 1);
                    state_d      = (BRANCH_FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                end else if (load_use) begin
                    stall_fetch_c  = 1'b1;
                    stall_decode_c = 1'b1;
                    nop_select_c   = 1'b1;
                    rem_d          = REM_W'(LOAD_USE_STALL - 1);
                    state_d        = (LOAD_USE_STALL > 1) ? ST_LOAD_STALL : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end

            // Execute holds a bubble here, so a branch in execute cannot be real.
            ST_LOAD_STALL: begin
                if (hcu.mem_busy) begin
                    stall_fetch_c  = 1'b1;
                    stall_decode_c = 1'b1;
                    freeze_all_c   = 1'b1;
                end else begin
                    stall_fetch_c  = 1'b1;
                    stall_decode_c = 1'b1;
                    nop_select_c   = 1'b1;
                    rem_d          = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) state_d = ST_RUN;
                end
            end

            // Wrong-path instructions are being squashed; their hazards are irrelevant.
            ST_FLUSH: begin
                if (hcu.mem_busy) begin
                    stall_fetch_c  = 1'b1;
                    stall_decode_c = 1'b1;
                    freeze_all_c   = 1'b1;
                end else begin
                    flush_fd_c   = 1'b1;
                    nop_select_c = 1'b1;
                    rem_d        = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) state_d = ST_RUN;
                end
            end

            default: state_d = ST_RUN;
        endcase

        if (reset) begin
            stall_fetch_c  = 1'b0;
            stall_decode_c = 1'b0;
            nop_select_c   = 1'b0;
            flush_fd_c     = 1'b0;
            freeze_all_c   = 1'b0;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_decode_c && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
        if (flush_fd_c && (flush_count_q != '1))     flush_count_d = flush_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            rem_q         <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign hcu.stall_fetch        = stall_fetch_c;
    assign hcu.stall_decode       = stall_decode_c;
    assign hcu.nop_select         = nop_select_c;
    assign hcu.flush_fetch_decode = flush_fd_c;
    assign hcu.freeze_all         = freeze_all_c;
    assign hcu.state_out          = state_q;
    assign hcu.stall_count        = stall_count_q;
    assign hcu.flush_count        = flush_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: default instance plus a LOAD_USE_STALL=3 instance,
// both driven with the same inputs; expectations queued per cycle and compared mid-cycle.
module tb_hazard_control_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.REG_ADDR_W(4), .CNT_W(16)) bus_a ();
    hazard_control_unit_if #(.REG_ADDR_W(4), .CNT_W(16)) bus_b ();

    hazard_control_unit dut_a (.clk(clk), .reset(reset), .hcu(bus_a));
    hazard_control_unit #(.LOAD_USE_STALL(3)) dut_b (.clk(clk), .reset(reset), .hcu(bus_b));

    // ctrl = {stall_fetch, stall_decode, nop_select, flush_fetch_decode, freeze_all}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_LU   = 5'b11100;
    localparam logic [4:0] C_FL   = 5'b00110;
    localparam logic [4:0] C_MB   = 5'b11001;
    localparam logic [1:0] S_RUN = 2'd0, S_LS = 2'd1, S_FL = 2'd2, S_MW = 2'd3;

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
        logic        chk;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          sel      = 0;
    logic [15:0] m_sc     = '0;
    logic [15:0] m_fc     = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_out();
        exp_t        e;
        logic [4:0]  oc;
        logic [1:0]  os;
        logic [15:0] osc, ofc;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: got 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        if (sel == 0) begin
            oc  = {bus_a.stall_fetch, bus_a.stall_decode, bus_a.nop_select,
                   bus_a.flush_fetch_decode, bus_a.freeze_all};
            os  = bus_a.state_out; osc = bus_a.stall_count; ofc = bus_a.flush_count;
        end else begin
            oc  = {bus_b.stall_fetch, bus_b.stall_decode, bus_b.nop_select,
                   bus_b.flush_fetch_decode, bus_b.freeze_all};
            os  = bus_b.state_out; osc = bus_b.stall_count; ofc = bus_b.flush_count;
        end
        if (e.chk) begin
            check_eq("ctrl", 32'(oc), 32'(e.ctrl));
            check_eq("state", 32'(os), 32'(e.st));
            check_eq("stall_count", 32'(osc), 32'(e.sc));
            check_eq("flush_count", 32'(ofc), 32'(e.fc));
        end
    endtask

    // One clock cycle: drive inputs, queue expected outputs, compare mid-cycle.
    task automatic step(input logic [4:0] c = C_NONE, input logic [1:0] s = S_RUN,
                        input logic r = 1'b0, input logic vd = 1'b0,
                        input logic [3:0] rs1 = 4'd0, input logic [3:0] rs2 = 4'd0,
                        input logic u2 = 1'b0, input logic [3:0] rd = 4'd0,
                        input logic wre = 1'b0, input logic ld = 1'b0,
                        input logic br = 1'b0, input logic mb = 1'b0,
                        input logic ck = 1'b1);
        reset = r;
        bus_a.valid_decode = vd;  bus_b.valid_decode = vd;
        bus_a.rs1_decode   = rs1; bus_b.rs1_decode   = rs1;
        bus_a.rs2_decode   = rs2; bus_b.rs2_decode   = rs2;
        bus_a.uses_rs2_decode = u2; bus_b.uses_rs2_decode = u2;
        bus_a.rd_execute   = rd;  bus_b.rd_execute   = rd;
        bus_a.wre_execute  = wre; bus_b.wre_execute  = wre;
        bus_a.load_execute = ld;  bus_b.load_execute = ld;
        bus_a.branch_taken_execute = br; bus_b.branch_taken_execute = br;
        bus_a.mem_busy     = mb;  bus_b.mem_busy     = mb;
        sb.push_back('{ctrl: c, st: s, sc: m_sc, fc: m_fc, chk: ck});
        if (r) begin
            m_sc = '0;
            m_fc = '0;
        end else begin
            if (c[3] && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            if (c[1] && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
        end
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.valid_decode = 0; bus_a.rs1_decode = 0; bus_a.rs2_decode = 0;
        bus_a.uses_rs2_decode = 0; bus_a.rd_execute = 0; bus_a.wre_execute = 0;
        bus_a.load_execute = 0; bus_a.branch_taken_execute = 0; bus_a.mem_busy = 0;
        bus_b.valid_decode = 0; bus_b.rs1_decode = 0; bus_b.rs2_decode = 0;
        bus_b.uses_rs2_decode = 0; bus_b.rd_execute = 0; bus_b.wre_execute = 0;
        bus_b.load_execute = 0; bus_b.branch_taken_execute = 0; bus_b.mem_busy = 0;
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;

        // Reset state, with a hazard on the inputs that must be masked.
        step(.r(1), .vd(1), .rs1(3), .rd(3), .wre(1), .ld(1), .br(1), .mb(1));
        step();

        // Load-use via rs1: exactly one bubble.
        step(.c(C_LU), .vd(1), .rs1(3), .rd(3), .wre(1), .ld(1));
        step();
        // Load-use via rs2.
        step(.c(C_LU), .vd(1), .rs1(5), .rs2(3), .u2(1), .rd(3), .wre(1), .ld(1));
        // R0 destination, rs2 match without uses_rs2, no write enable, invalid decode.
        step(.vd(1), .rs1(0), .rd(0), .wre(1), .ld(1));
        step(.vd(1), .rs1(1), .rs2(4), .u2(0), .rd(4), .wre(1), .ld(1));
        step(.vd(1), .rs1(4), .rd(4), .wre(0), .ld(1));
        step(.vd(0), .rs1(4), .rd(4), .wre(1), .ld(1));
        // Non-load writer does not stall.
        step(.vd(1), .rs1(4), .rd(4), .wre(1), .ld(0));

        // Taken branch: two flush cycles; branch/load-use in FLUSH ignored.
        step(.c(C_FL), .br(1));
        step(.c(C_FL), .s(S_FL), .br(1), .vd(1), .rs1(3), .rd(3), .wre(1), .ld(1));
        step();

        // Priority: mem_busy beats branch and load-use; release with branch flushes at once.
        step(.c(C_MB), .mb(1), .br(1), .vd(1), .rs1(3), .rd(3), .wre(1), .ld(1));
        step(.c(C_MB), .s(S_MW), .mb(1), .br(1));
        step(.c(C_FL), .s(S_MW), .br(1));
        step(.c(C_FL), .s(S_FL));
        step();

        // mem_busy in the first FLUSH cycle for 3 cycles, then one remaining flush cycle.
        step(.c(C_FL), .br(1));
        step(.c(C_MB), .s(S_FL), .mb(1));
        step(.c(C_MB), .s(S_FL), .mb(1));
        step(.c(C_MB), .s(S_FL), .mb(1));
        step(.c(C_FL), .s(S_FL));
        step();

        // Release from MEM_WAIT with a load-use pending stalls in the release cycle.
        step(.c(C_MB), .mb(1));
        step(.c(C_LU), .s(S_MW), .vd(1), .rs1(7), .rd(7), .wre(1), .ld(1));
        step();

        // Switch to the LOAD_USE_STALL=3 instance.
        step(.r(1));
        sel = 1;
        step(.r(1));
        step(.c(C_LU), .vd(1), .rs1(3), .rd(3), .wre(1), .ld(1));
        step(.c(C_LU), .s(S_LS), .br(1));
        step(.c(C_LU), .s(S_LS));
        step();
        // Reset mid-LOAD_STALL aborts the sequence.
        step(.c(C_LU), .vd(1), .rs1(9), .rd(9), .wre(1), .ld(1));
        step(.c(C_NONE), .s(S_LS), .r(1));
        step();

        // Back to the default instance for counter saturation.
        step(.r(1));
        sel = 0;
        step(.r(1));
        for (int i = 0; i < 65540; i++) begin
            step(.c(C_MB), .s((i == 0) ? S_RUN : S_MW), .mb(1), .ck(0));
        end
        step(.c(C_MB), .s(S_MW), .mb(1));
        step(.c(C_NONE), .s(S_MW));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
